effect_led_renderer: RTL
========================

# effect_led_renderer

Consumer end of the visual-effect interface: accepts effect_type / effect_data / brightness / speed / effect_ready from the effect generator and renders them onto an 8-LED bar as glitch-free PWM. It sits between the effect generator and the board LED pins. It latches parameters only at PWM-period boundaries and advances an internal animation phase at a rate set by speed.

## Interface
- PRESCALE, default 4: clocks per PWM count; PWM period = PRESCALE×256 clk, about 85 µs at 12 MHz.
- clk  in  1  system clock, 12 MHz.
- rst  in  1  reset: synchronous, active-high, single clock domain.
- effect_type  in  8  effect code, 0x01–0x08.
- effect_data  in  16  effect payload.
- brightness  in  8  peak duty, 0–255.
- speed  in  8  animation rate.
- effect_ready  in  1  level-valid qualifier for the four inputs above.
- led  out  8  PWM LED drive, active-high, registered.
- frame_tick  out  1  one-cycle pulse per animation step.
- active_effect  out  8  currently latched effect code; 0 while IDLE.

## Operation
- The prescaler counts 0..PRESCALE−1. pwm_cnt[7:0] increments when the prescaler wraps.
- Boundary (bnd) = prescaler at PRESCALE−1 and pwm_cnt == 255.
- **Load:** at bnd with effect_ready=1, latch type_s, data_s, bright_s and speed_s.
  - If the new type_s differs from the previous type_s, clear phase to 0.
  - If effect_ready=0 at bnd, hold all shadows.
- **Step:** at every bnd, acc[15:0] += speed_s + 1 (17-bit sum).
  - A carry out increments phase[7:0] (mod 256) and pulses frame_tick.
  - Load and step in the same bnd cycle: the step uses the old speed_s. Phase clears if the type changed, otherwise it increments.
- **FSM:**
  - IDLE → RUN on a load with a type in 0x01–0x08.
  - RUN → IDLE on a load with any other type.
  - In IDLE, all duties are 0 and active_effect=0.
- **Per-LED duty,** recomputed each cycle from shadows and phase. Let b = bright_s and d = data_s.
  - 0x01 breathing: all LEDs = (d[7:0]×b)>>8, using a 16-bit product.
  - 0x02 flowing: LED d[2:0] = b; LED (d[2:0]−1) mod 8 = b>>2; others 0.
  - 0x03 spectrum: LED i = b if d[2i+1]|d[2i], else 0.
  - 0x04 waveform: ping-pong position p = phase[3] ? 7−phase[2:0] : phase[2:0]; LED p = b, others 0.
  - 0x05 beat: all LEDs = (d[7:0] ≥ 0x80) ? b : b>>3.
  - 0x06 rainbow: LED i = b if bit i of rotl(8'h0F, phase[2:0]) is set.
  - 0x07 sparkle: LED i = b if d[i], else 0.
  - 0x08 pulse: all LEDs = phase[0] ? b : 0.
- **Output:** led[i] <= (pwm_cnt < duty_i), registered.
  - Duty 0 gives a constant low output.
  - Duty 255 gives 255/256 high; led is never a constant 1.

## Timing
- Reset values: led=0, frame_tick=0, active_effect=0, all shadows/acc/phase/pwm_cnt/prescaler=0, FSM=IDLE.
- Load latency: inputs sampled in the bnd cycle T; active_effect updates at T+1; led reflects new duties from the first cycle of the next PWM period.
- Inputs changing mid-period never alter led within that period.
- Step period = ceil(65536/(speed_s+1)) PWM periods.
  - speed 0xFF: 256 periods, about 21.8 ms.
  - speed 0x00: 65536 periods.
- frame_tick is asserted in cycle T+1 after the carrying bnd, for exactly 1 clk.
- rst mid-operation: all state returns to reset values on the next clock edge, regardless of phase or FSM state.

## Structure
- Shared package effect_pkg holds:
  - the effect codes 0x01–0x08, used by both generator and renderer;
  - PWM_BITS = 8;
  - the FSM state enum {IDLE, RUN}.
- One sub-module, led_pwm_bank, contains the prescaler, pwm_cnt, bnd generation and the 8 registered comparators.
- Top level keeps the shadows, acc/phase, FSM and the duty mux.

## Test plan
- Reset then idle: rst for 2 clk, effect_ready=0 for 3 PWM periods → led=0, active_effect=0, no frame_tick.
- Sparkle: type 0x07, data 0x00A5, bright 0x80, ready=1 → from the next period, LEDs 0,2,5,7 are high 128/256 of each period; others stay low.
- Breathing scaling: type 0x01, data 0x0080, bright 0xFF → all LEDs at duty 0x7F (127 of 256 counts).
- Step rate and waveform: type 0x04, speed 0xFF, bright 0xFF → frame_tick every 256 PWM periods; lit LED sequence 0..7, 7..0, repeating.
- Mid-period change: switch type from 0x01 to 0x08 at pwm_cnt=100 → waveform unchanged until bnd; phase resets to 0; all LEDs low during the first pulse period.
- Invalid type and mid-run reset: load type 0x00 → IDLE with led=0 and active_effect=0; assert rst during RUN → all outputs 0 on the next edge.

Source files
------------

// File: rtl/effect_pkg.sv
// Shared definitions for the visual-effect interface: effect codes, PWM width,
// renderer FSM states and a small rotate helper used by the duty mux.
package effect_pkg;

   localparam int PWM_BITS = 8;
   localparam int NUM_LEDS = 8;

   localparam logic [7:0] EFF_BREATHING = 8'h01;
   localparam logic [7:0] EFF_FLOWING   = 8'h02;
   localparam logic [7:0] EFF_SPECTRUM  = 8'h03;
   localparam logic [7:0] EFF_WAVEFORM  = 8'h04;
   localparam logic [7:0] EFF_BEAT      = 8'h05;
   localparam logic [7:0] EFF_RAINBOW   = 8'h06;
   localparam logic [7:0] EFF_SPARKLE   = 8'h07;
   localparam logic [7:0] EFF_PULSE     = 8'h08;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic is_valid_effect(input logic [7:0] code);
      return (code >= EFF_BREATHING) && (code <= EFF_PULSE);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input logic [2:0] n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

endpackage

// File: rtl/led_pwm_bank.sv
// PWM timebase (prescaler + 8-bit count), period-boundary strobe and the eight
// registered duty comparators that drive the LED pins.
module led_pwm_bank
   import effect_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty,
   output logic                               bnd,
   output logic [NUM_LEDS-1:0]                led
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]       pre_q, pre_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                pre_wrap;

   always_comb begin
      pre_wrap = (pre_q == PRE_LAST);
      pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
      cnt_d    = pre_wrap ? cnt_q + 1'b1 : cnt_q;
      bnd      = pre_wrap && (cnt_q == '1);
   end

   // Strict less-than: duty 0 is always dark, duty 255 still drops for one count.
   generate
      for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_cmp
         assign led_d[gi] = (cnt_q < duty[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         cnt_q <= '0;
         led_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/effect_led_renderer.sv
// Renders latched effect parameters onto an 8-LED PWM bar; parameters and the
// animation phase only change at PWM period boundaries so the output never glitches.
module effect_led_renderer
   import effect_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  effect_type,
   input  logic [15:0] effect_data,
   input  logic [7:0]  brightness,
   input  logic [7:0]  speed,
   input  logic        effect_ready,
   output logic [7:0]  led,
   output logic        frame_tick,
   output logic [7:0]  active_effect
);

   logic [7:0]  type_q, type_d;
   logic [15:0] data_q, data_d;
   logic [7:0]  bright_q, bright_d;
   logic [7:0]  speed_q, speed_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  phase_q, phase_d;
   logic        tick_q, tick_d;
   logic [7:0]  active_q, active_d;
   state_e      state_q, state_d;

   logic                              bnd;
   logic [16:0]                       step_sum;
   logic [NUM_LEDS-1:0][PWM_BITS-1:0] duty;
   logic [15:0]                       prod;
   logic [2:0]                        flow_idx, flow_prev, wave_pos;
   logic [7:0]                        rain_mask;

   // The step always uses the speed latched before this boundary; a type change
   // then overrides any phase increment with a clear.
   always_comb begin
      type_d   = type_q;
      data_d   = data_q;
      bright_d = bright_q;
      speed_d  = speed_q;
      acc_d    = acc_q;
      phase_d  = phase_q;
      state_d  = state_q;
      tick_d   = 1'b0;
      step_sum = {1'b0, acc_q} + {9'd0, speed_q} + 17'd1;
      if (bnd) begin
         acc_d  = step_sum[15:0];
         tick_d = step_sum[16];
         if (step_sum[16]) phase_d = phase_q + 1'b1;
         if (effect_ready) begin
            type_d   = effect_type;
            data_d   = effect_data;
            bright_d = brightness;
            speed_d  = speed;
            if (effect_type != type_q) phase_d = '0;
            state_d  = is_valid_effect(effect_type) ? RUN : IDLE;
         end
      end
      active_d = (state_d == RUN) ? type_d : 8'h00;
   end

   always_comb begin
      duty      = '0;
      prod      = 16'(data_q[7:0]) * 16'(bright_q);
      flow_idx  = data_q[2:0];
      flow_prev = flow_idx - 3'd1;
      wave_pos  = phase_q[3] ? (3'd7 - phase_q[2:0]) : phase_q[2:0];
      rain_mask = rotl8(8'h0F, phase_q[2:0]);
      if (state_q == RUN) begin
         case (type_q)
            EFF_BREATHING: duty = {NUM_LEDS{prod[15:8]}};
            EFF_FLOWING: begin
               duty[flow_idx]  = bright_q;
               duty[flow_prev] = bright_q >> 2;
            end
            EFF_SPECTRUM: begin
               for (int i = 0; i < NUM_LEDS; i++)
                  duty[i] = (data_q[2*i+1] | data_q[2*i]) ? bright_q : 8'h00;
            end
            EFF_WAVEFORM: duty[wave_pos] = bright_q;
            EFF_BEAT: duty = {NUM_LEDS{data_q[7] ? bright_q : (bright_q >> 3)}};
            EFF_RAINBOW: begin
               for (int i = 0; i < NUM_LEDS; i++)
                  duty[i] = rain_mask[i] ? bright_q : 8'h00;
            end
            EFF_SPARKLE: begin
               for (int i = 0; i < NUM_LEDS; i++)
                  duty[i] = data_q[i] ? bright_q : 8'h00;
            end
            EFF_PULSE: duty = {NUM_LEDS{phase_q[0] ? bright_q : 8'h00}};
            default: duty = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         type_q   <= '0;
         data_q   <= '0;
         bright_q <= '0;
         speed_q  <= '0;
         acc_q    <= '0;
         phase_q  <= '0;
         tick_q   <= 1'b0;
         active_q <= '0;
         state_q  <= IDLE;
      end else begin
         type_q   <= type_d;
         data_q   <= data_d;
         bright_q <= bright_d;
         speed_q  <= speed_d;
         acc_q    <= acc_d;
         phase_q  <= phase_d;
         tick_q   <= tick_d;
         active_q <= active_d;
         state_q  <= state_d;
      end
   end

   led_pwm_bank #(
      .PRESCALE (PRESCALE)
   ) u_pwm (
      .clk  (clk),
      .rst  (rst),
      .duty (duty),
      .bnd  (bnd),
      .led  (led)
   );

   assign frame_tick    = tick_q;
   assign active_effect = active_q;

endmodule
